residual_stream_feeder: RTL and testbench

Sequencer that drives the residual-add vector lane from both ends of its stream interface. It reads the main-path and residual-path operand rows from two activation SRAM banks and issues them as valid-tagged 128-bit beats with a relative address and a finish marker. It then collects the returned beats and writes them back to a destination base address. It sits between the vector-engine SRAM arbiter and the 16-lane residual adder, and reports busy/done to the layer controller.

---
 rtl/residual_pkg.sv | 20 ++
 rtl/residual_stream_feeder_if.sv | 40 ++++
 rtl/feeder_delay_line.sv | 43 ++++
 rtl/residual_stream_feeder.sv | 215 +++++++++++++++++++++
 tb/tb_residual_stream_feeder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/residual_pkg.sv
// Shared constants and types for the residual-add feeder.
//   DEF_ADDR_W / DEF_DATA_W : default SRAM row address / row data widths
//   SCALE_W / SHIFT_W       : dequant scale and requant shift widths
//   feeder_state_e          : sequencer FSM states
package residual_pkg;

    localparam int unsigned DEF_ADDR_W = 9;
    localparam int unsigned DEF_DATA_W = 128;
    localparam int unsigned SCALE_W    = 10;
    localparam int unsigned SHIFT_W    = 5;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StDrain,
        StFin
    } feeder_state_e;

endpackage

// File: rtl/residual_stream_feeder_if.sv
// Stream interface between the feeder and the 16-lane residual adder.
//   scale_vld/scale_a/scale_b, shift_vld/shift : parameter load pulses to the adder
//   in_data_a/in_data_b/in_data_vld/in_addr/in_finish : operand beats to the adder
//   out_data/out_data_vld/out_addr/out_finish : result beats back from the adder
// master = feeder side, slave = adder side.
interface residual_stream_feeder_if
    import residual_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic               scale_vld;
    logic [SCALE_W-1:0] scale_a;
    logic [SCALE_W-1:0] scale_b;
    logic               shift_vld;
    logic [SHIFT_W-1:0] shift;

    logic [DATA_W-1:0]  in_data_a;
    logic [DATA_W-1:0]  in_data_b;
    logic               in_data_vld;
    logic [ADDR_W-1:0]  in_addr;
    logic               in_finish;

    logic [DATA_W-1:0]  out_data;
    logic               out_data_vld;
    logic [ADDR_W-1:0]  out_addr;
    logic               out_finish;

    modport master (
        output scale_vld, scale_a, scale_b, shift_vld, shift,
        output in_data_a, in_data_b, in_data_vld, in_addr, in_finish,
        input  out_data, out_data_vld, out_addr, out_finish
    );

    modport slave (
        input  scale_vld, scale_a, scale_b, shift_vld, shift,
        input  in_data_a, in_data_b, in_data_vld, in_addr, in_finish,
        output out_data, out_data_vld, out_addr, out_finish
    );
endinterface

// File: rtl/feeder_delay_line.sv
// Fixed-depth shift register carrying {vld, idx, last} so that beat tags line up
// with data returning from a pipelined SRAM read.
//   clk, rst_n                  : clock, async active-low reset
//   src_vld, src_idx, src_last  : tag entering the line (same cycle as the read strobe)
//   dly_vld, dly_idx, dly_last  : tag leaving the line Depth cycles later
module feeder_delay_line #(
    parameter int unsigned Depth = 1,
    parameter int unsigned IdxW  = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            src_vld,
    input  logic [IdxW-1:0] src_idx,
    input  logic            src_last,
    output logic            dly_vld,
    output logic [IdxW-1:0] dly_idx,
    output logic            dly_last
);
    logic [Depth-1:0]           vld_q;
    logic [Depth-1:0]           last_q;
    logic [Depth-1:0][IdxW-1:0] idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            idx_q  <= '0;
        end else begin
            vld_q[0]  <= src_vld;
            last_q[0] <= src_last;
            idx_q[0]  <= src_idx;
            for (int i = 1; i < int'(Depth); i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                idx_q[i]  <= idx_q[i-1];
            end
        end
    end

    assign dly_vld  = vld_q[Depth-1];
    assign dly_idx  = idx_q[Depth-1];
    assign dly_last = last_q[Depth-1];
endmodule

// File: rtl/residual_stream_feeder.sv
// Residual-add lane sequencer. Reads main-path (bank A) and residual (bank B) rows,
// issues them to the adder as tagged beats, and writes the returned results back.
//   clk, rst_n        : clock, async active-low reset
//   cfg_*             : run configuration, latched on cfg_vld while idle
//   start/busy/done   : layer-controller handshake
//   rd_gnt            : arbiter grant for both read banks
//   a_rd_*/b_rd_*     : SRAM read strobes, rows and returned data (RD_LAT cycles)
//   lane              : adder stream interface (operands out, results in)
//   wr_en/wr_addr/wr_data : registered writeback port
module residual_stream_feeder
    import residual_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_vld,
    input  logic [ADDR_W-1:0]  cfg_base_a,
    input  logic [ADDR_W-1:0]  cfg_base_b,
    input  logic [ADDR_W-1:0]  cfg_base_o,
    input  logic [ADDR_W:0]    cfg_len,
    input  logic [SCALE_W-1:0] cfg_scale_a,
    input  logic [SCALE_W-1:0] cfg_scale_b,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               rd_gnt,
    output logic               a_rd_en,
    output logic               b_rd_en,
    output logic [ADDR_W-1:0]  a_rd_addr,
    output logic [ADDR_W-1:0]  b_rd_addr,
    input  logic [DATA_W-1:0]  a_rd_data,
    input  logic [DATA_W-1:0]  b_rd_data,
    residual_stream_feeder_if.master lane,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data
);
    localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

    feeder_state_e state_q, state_d;

    logic [ADDR_W-1:0]  base_a_q, base_b_q, base_o_q;
    logic [ADDR_W:0]    len_q;
    logic [SCALE_W-1:0] scale_a_q, scale_b_q;
    logic [SHIFT_W-1:0] shift_q;

    logic [ADDR_W:0]    idx_q, idx_d;
    logic [ADDR_W:0]    ret_cnt_q, ret_cnt_d;
    logic               fin_seen_q, fin_seen_d;

    logic               cfg_load;
    logic               strobe;
    logic               strobe_last;
    logic               accept;

    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;

    logic [DATA_W-1:0]  hold_a_q, hold_b_q;
    logic [ADDR_W-1:0]  hold_addr_q;

    logic               dly_vld, dly_last;
    logic [ADDR_W-1:0]  dly_idx;

    assign busy = (state_q == StLoad) || (state_q == StIssue) || (state_q == StDrain);
    assign done = (state_q == StFin);

    assign strobe_last = (idx_q == (len_q - CntOne));

    // Results are taken only while a run is active and only up to len beats.
    assign accept = busy && lane.out_data_vld && (ret_cnt_q < len_q);

    always_comb begin
        ret_cnt_d  = ret_cnt_q;
        fin_seen_d = fin_seen_q;
        if (state_q == StFin) begin
            ret_cnt_d  = '0;
            fin_seen_d = 1'b0;
        end else begin
            if (accept) begin
                ret_cnt_d = ret_cnt_q + CntOne;
            end
            if (busy && lane.out_data_vld && lane.out_finish) begin
                fin_seen_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cfg_load = 1'b0;
        strobe   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cfg_load = cfg_vld;
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = (len_q != '0) ? StIssue : StFin;
            end
            StIssue: begin
                if (rd_gnt) begin
                    strobe = 1'b1;
                    idx_d  = idx_q + CntOne;
                    if (strobe_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Uses the next-state counters so the beat arriving now can finish the run.
                if ((ret_cnt_d == len_q) && fin_seen_d) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                idx_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_o_q    <= '0;
            len_q       <= '0;
            scale_a_q   <= '0;
            scale_b_q   <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            ret_cnt_q   <= '0;
            fin_seen_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            hold_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ret_cnt_q  <= ret_cnt_d;
            fin_seen_q <= fin_seen_d;
            if (cfg_load) begin
                base_a_q  <= cfg_base_a;
                base_b_q  <= cfg_base_b;
                base_o_q  <= cfg_base_o;
                len_q     <= cfg_len;
                scale_a_q <= cfg_scale_a;
                scale_b_q <= cfg_scale_b;
                shift_q   <= cfg_shift;
            end
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= base_o_q + lane.out_addr;
                wr_data_q <= lane.out_data;
            end
            if (dly_vld) begin
                hold_a_q    <= a_rd_data;
                hold_b_q    <= b_rd_data;
                hold_addr_q <= dly_idx;
            end
        end
    end

    feeder_delay_line #(
        .Depth (RD_LAT),
        .IdxW  (ADDR_W)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_vld  (strobe),
        .src_idx  (idx_q[ADDR_W-1:0]),
        .src_last (strobe_last),
        .dly_vld  (dly_vld),
        .dly_idx  (dly_idx),
        .dly_last (dly_last)
    );

    assign a_rd_en   = strobe;
    assign b_rd_en   = strobe;
    assign a_rd_addr = base_a_q + idx_q[ADDR_W-1:0];
    assign b_rd_addr = base_b_q + idx_q[ADDR_W-1:0];

    assign lane.scale_vld = (state_q == StLoad);
    assign lane.shift_vld = (state_q == StLoad);
    assign lane.scale_a   = scale_a_q;
    assign lane.scale_b   = scale_b_q;
    assign lane.shift     = shift_q;

    // Beat fields pass read data through when valid and hold the last beat otherwise.
    assign lane.in_data_vld = dly_vld;
    assign lane.in_finish   = dly_vld && dly_last;
    assign lane.in_addr     = dly_vld ? dly_idx : hold_addr_q;
    assign lane.in_data_a   = dly_vld ? a_rd_data : hold_a_q;
    assign lane.in_data_b   = dly_vld ? b_rd_data : hold_b_q;

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: tb/tb_residual_stream_feeder.sv
`timescale 1ns/1ps
module tb_residual_stream_feeder;
    import residual_pkg::*;

    localparam int unsigned AW  = DEF_ADDR_W;
    localparam int unsigned DW  = DEF_DATA_W;
    localparam int unsigned LAT = 3;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } rd_t;
    typedef struct packed {
        logic [AW-1:0] idx;
        logic          fin;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } beat_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               cfg_vld = 1'b0;
    logic [AW-1:0]      cfg_base_a = '0, cfg_base_b = '0, cfg_base_o = '0;
    logic [AW:0]        cfg_len = '0;
    logic [SCALE_W-1:0] cfg_scale_a = '0, cfg_scale_b = '0;
    logic [SHIFT_W-1:0] cfg_shift = '0;
    logic               start = 1'b0;
    logic               rd_gnt = 1'b0;
    logic               busy, done;
    logic               a_rd_en, b_rd_en;
    logic [AW-1:0]      a_rd_addr, b_rd_addr;
    logic [DW-1:0]      a_rd_data, b_rd_data;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;

    residual_stream_feeder_if #(.ADDR_W(AW), .DATA_W(DW)) lane ();

    residual_stream_feeder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_vld     (cfg_vld),
        .cfg_base_a  (cfg_base_a),
        .cfg_base_b  (cfg_base_b),
        .cfg_base_o  (cfg_base_o),
        .cfg_len     (cfg_len),
        .cfg_scale_a (cfg_scale_a),
        .cfg_scale_b (cfg_scale_b),
        .cfg_shift   (cfg_shift),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_gnt      (rd_gnt),
        .a_rd_en     (a_rd_en),
        .b_rd_en     (b_rd_en),
        .a_rd_addr   (a_rd_addr),
        .b_rd_addr   (b_rd_addr),
        .a_rd_data   (a_rd_data),
        .b_rd_data   (b_rd_data),
        .lane        (lane),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    // SRAM contents are a fixed function of the row, distinct per bank.
    function automatic logic [DW-1:0] a_row(input logic [AW-1:0] r);
        logic [22:0] s;
        s = 23'h5A5A5A ^ {14'd0, r};
        return {4{s, r}};
    endfunction
    function automatic logic [DW-1:0] b_row(input logic [AW-1:0] r);
        logic [22:0] s;
        s = 23'h3C3C3C ^ {r, 14'd0};
        return {4{r, s}};
    endfunction

    // SRAM model: data appears LAT cycles after a strobe, zero otherwise.
    logic [LAT-1:0] a_vp = '0, b_vp = '0;
    logic [AW-1:0]  a_pa [LAT];
    logic [AW-1:0]  b_pa [LAT];
    always @(posedge clk) begin
        a_vp[0] <= a_rd_en;
        b_vp[0] <= b_rd_en;
        a_pa[0] <= a_rd_addr;
        b_pa[0] <= b_rd_addr;
        for (int i = 1; i < int'(LAT); i++) begin
            a_vp[i] <= a_vp[i-1];
            b_vp[i] <= b_vp[i-1];
            a_pa[i] <= a_pa[i-1];
            b_pa[i] <= b_pa[i-1];
        end
    end
    assign a_rd_data = a_vp[LAT-1] ? a_row(a_pa[LAT-1]) : '0;
    assign b_rd_data = b_vp[LAT-1] ? b_row(b_pa[LAT-1]) : '0;

    // Adder model: one-cycle latency, result = a ^ b, tags forwarded.
    logic          mdl_vld = 1'b0, mdl_fin = 1'b0;
    logic [AW-1:0] mdl_addr = '0;
    logic [DW-1:0] mdl_data = '0;
    logic          stray_vld = 1'b0, stray_fin = 1'b0;
    always @(posedge clk) begin
        mdl_vld  <= lane.in_data_vld;
        mdl_fin  <= lane.in_finish;
        mdl_addr <= lane.in_addr;
        mdl_data <= lane.in_data_a ^ lane.in_data_b;
    end
    assign lane.out_data_vld = mdl_vld | stray_vld;
    assign lane.out_finish   = stray_vld ? stray_fin : mdl_fin;
    assign lane.out_addr     = stray_vld ? 9'h055 : mdl_addr;
    assign lane.out_data     = stray_vld ? {16{8'hEE}} : mdl_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not expected (t=%0t)", name, $time);
    endtask

    // Scoreboard queues, filled when a run is issued.
    rd_t   rd_q[$];
    beat_t beat_q[$];
    wr_t   wr_q[$];
    int    scyc_q[$];

    logic [SCALE_W-1:0] exp_sa = '0, exp_sb = '0;
    logic [SHIFT_W-1:0] exp_sh = '0;
    int    rd_seen = 0, scale_cnt = 0, wr_seen = 0;
    bit    mon_en = 1'b0;
    bit    prev_vld = 1'b0;
    beat_t last_b;
    rd_t   m_rd;
    beat_t m_bt;
    wr_t   m_wr;
    int    m_sc;

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            if (a_rd_en || b_rd_en) begin
                if (rd_q.size() == 0) begin
                    flag("rd_strobe");
                end else begin
                    m_rd = rd_q.pop_front();
                    chk("a_rd_en", a_rd_en, 1);
                    chk("b_rd_en", b_rd_en, 1);
                    chk("a_rd_addr", a_rd_addr, m_rd.a);
                    chk("b_rd_addr", b_rd_addr, m_rd.b);
                end
                rd_seen++;
                scyc_q.push_back(cyc);
            end
            if (lane.scale_vld || lane.shift_vld) begin
                chk("scale_vld", lane.scale_vld, 1);
                chk("shift_vld", lane.shift_vld, 1);
                chk("scale_a", lane.scale_a, exp_sa);
                chk("scale_b", lane.scale_b, exp_sb);
                chk("shift", lane.shift, exp_sh);
                chk("scale_before_rd", rd_seen, 0);
                scale_cnt++;
            end
            if (lane.in_data_vld) begin
                if (beat_q.size() == 0) begin
                    flag("in_data_vld");
                end else begin
                    m_bt = beat_q.pop_front();
                    chk("in_addr", lane.in_addr, m_bt.idx);
                    chk("in_finish", lane.in_finish, m_bt.fin);
                    chk("in_data_a", lane.in_data_a, m_bt.a);
                    chk("in_data_b", lane.in_data_b, m_bt.b);
                    if (scyc_q.size() == 0) begin
                        flag("beat_without_strobe");
                    end else begin
                        m_sc = scyc_q.pop_front();
                        chk("beat_latency", cyc - m_sc, LAT);
                    end
                    last_b = m_bt;
                end
                prev_vld = 1'b1;
            end else begin
                if (prev_vld) begin
                    chk("hold_addr", lane.in_addr, last_b.idx);
                    chk("hold_data_a", lane.in_data_a, last_b.a);
                    chk("hold_finish", lane.in_finish, 0);
                end
                prev_vld = 1'b0;
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    flag("wr_en");
                end else begin
                    m_wr = wr_q.pop_front();
                    chk("wr_addr", wr_addr, m_wr.addr);
                    chk("wr_data", wr_data, m_wr.data);
                end
                wr_seen++;
            end
        end
    end

    task automatic push_exp(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                            input logic [AW-1:0] bo, input logic [AW:0] len,
                            input logic [SCALE_W-1:0] sa, input logic [SCALE_W-1:0] sb,
                            input logic [SHIFT_W-1:0] sh);
        rd_t   r;
        beat_t bt;
        wr_t   w;
        exp_sa = sa;
        exp_sb = sb;
        exp_sh = sh;
        rd_seen = 0;
        scale_cnt = 0;
        wr_seen = 0;
        for (int i = 0; i < int'(len); i++) begin
            r.a = ba + i[AW-1:0];
            r.b = bb + i[AW-1:0];
            rd_q.push_back(r);
            bt.idx = i[AW-1:0];
            bt.fin = (i == int'(len) - 1);
            bt.a = a_row(r.a);
            bt.b = b_row(r.b);
            beat_q.push_back(bt);
            w.addr = bo + i[AW-1:0];
            w.data = a_row(r.a) ^ b_row(r.b);
            wr_q.push_back(w);
        end
    endtask

    task automatic kick(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                        input logic [AW-1:0] bo, input logic [AW:0] len,
                        input logic [SCALE_W-1:0] sa, input logic [SCALE_W-1:0] sb,
                        input logic [SHIFT_W-1:0] sh, input int mode);
        @(negedge clk);
        cfg_base_a = ba;
        cfg_base_b = bb;
        cfg_base_o = bo;
        cfg_len = len;
        cfg_scale_a = sa;
        cfg_scale_b = sb;
        cfg_shift = sh;
        cfg_vld = 1'b1;
        start = 1'b1;
        rd_gnt = (mode == 0);
        @(negedge clk);
        cfg_vld = 1'b0;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    // mode 0: grant every cycle; mode 1: grant alternate cycles.
    // disturb: pulse start and a conflicting cfg_vld in the middle of the run.
    task automatic run(input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                       input logic [AW-1:0] bo, input logic [AW:0] len,
                       input logic [SCALE_W-1:0] sa, input logic [SCALE_W-1:0] sb,
                       input logic [SHIFT_W-1:0] sh, input int mode, input bit disturb,
                       input int max_cyc);
        int k;
        bit got;
        push_exp(ba, bb, bo, len, sa, sb, sh);
        kick(ba, bb, bo, len, sa, sb, sh, mode);
        k = 1;
        got = 1'b0;
        while (!got && k < max_cyc) begin
            if (done) begin
                got = 1'b1;
            end else begin
                rd_gnt = (mode == 0) ? 1'b1 : (k % 2 == 0);
                if (disturb && k == 4) begin
                    cfg_vld = 1'b1;
                    start = 1'b1;
                    cfg_len = 10'd9;
                    cfg_base_a = 9'h100;
                    cfg_base_o = 9'h0C0;
                    cfg_scale_a = 10'h3FF;
                end else begin
                    cfg_vld = 1'b0;
                    start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        if (!got) flag("done_timeout");
        if (len == 0) chk("done_latency_len0", k, 2);
        rd_gnt = 1'b0;
        cfg_vld = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        repeat (LAT + 4) @(negedge clk);
        chk("rd_remaining", rd_q.size(), 0);
        chk("beat_remaining", beat_q.size(), 0);
        chk("wr_remaining", wr_q.size(), 0);
        chk("scale_pulses", scale_cnt, 1);
        chk("write_count", wr_seen, len);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_a_rd_en"}, a_rd_en, 0);
        chk({tag, "_b_rd_en"}, b_rd_en, 0);
        chk({tag, "_a_rd_addr"}, a_rd_addr, 0);
        chk({tag, "_b_rd_addr"}, b_rd_addr, 0);
        chk({tag, "_scale_vld"}, lane.scale_vld, 0);
        chk({tag, "_shift_vld"}, lane.shift_vld, 0);
        chk({tag, "_scale_a"}, lane.scale_a, 0);
        chk({tag, "_shift"}, lane.shift, 0);
        chk({tag, "_in_vld"}, lane.in_data_vld, 0);
        chk({tag, "_in_addr"}, lane.in_addr, 0);
        chk({tag, "_in_finish"}, lane.in_finish, 0);
        chk({tag, "_in_data_a"}, lane.in_data_a, 0);
        chk({tag, "_in_data_b"}, lane.in_data_b, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run, continuous grant.
        run(9'h010, 9'h020, 9'h030, 10'd4, 10'h123, 10'h045, 5'd7, 0, 1'b0, 60);
        // Same config, alternating grant.
        run(9'h010, 9'h020, 9'h030, 10'd4, 10'h2AA, 10'h155, 5'd3, 1, 1'b0, 60);
        // Address wrap on read and writeback.
        run(9'h1FE, 9'h0F0, 9'h1FF, 10'd4, 10'h001, 10'h3FF, 5'd31, 0, 1'b0, 60);
        // Zero-length run: done only, no traffic.
        run(9'h044, 9'h055, 9'h066, 10'd0, 10'h0F0, 10'h00F, 5'd1, 0, 1'b0, 20);
        // start and cfg_vld while busy are ignored.
        run(9'h010, 9'h020, 9'h030, 10'd4, 10'h111, 10'h222, 5'd9, 1, 1'b1, 60);

        // Stray result beat while idle must not write.
        @(negedge clk);
        stray_vld = 1'b1;
        stray_fin = 1'b1;
        @(negedge clk);
        stray_vld = 1'b0;
        stray_fin = 1'b0;
        chk("stray_wr_en", wr_en, 0);
        @(negedge clk);
        chk("stray_wr_en_late", wr_en, 0);
        chk("stray_busy", busy, 0);

        // Long run interrupted by reset around idx 200.
        push_exp(9'h000, 9'h100, 9'h080, 10'd512, 10'h0AB, 10'h0CD, 5'd4);
        kick(9'h000, 9'h100, 9'h080, 10'd512, 10'h0AB, 10'h0CD, 5'd4, 0);
        k = 0;
        while (rd_seen < 200 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (rd_seen < 200) flag("reach_idx200_timeout");
        mon_en = 1'b0;
        rst_n = 1'b0;
        rd_gnt = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        rd_q.delete();
        beat_q.delete();
        wr_q.delete();
        scyc_q.delete();
        prev_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_busy", busy, 0);
        run(9'h000, 9'h100, 9'h080, 10'd512, 10'h0AB, 10'h0CD, 5'd4, 0, 1'b0, 1200);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
